// File: rtl/encoder_4x2_debounced.sv
// rtl/encoder_4x2_debounced.sv - debounced 4-to-2 priority encoder with valid/ack handshake
//
// Purpose: synchronizes four request lines, then encodes the highest set line.
// A code is presented only after it has been stable for DEBOUNCE_CYCLES
// cycles. After the consumer acknowledges a code, every line must be released
// for DEBOUNCE_CYCLES cycles before the block accepts another code.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst    asynchronous active-high reset
//   D[3:0] asynchronous request lines, 1 = asserted, D[3] has highest priority
//   E      enable, sampled directly without a synchronizer
//   ack    consumer acknowledge of the presented code (used only while valid)
//   A[1:0] encoded index of the accepted line (registered)
//   V      accepted code is valid (registered)
//   MULTI  more than one line was set when the code was captured (registered)
//   CNT    count of accepted codes, wraps modulo 256 (registered)

module encoder_4x2_debounced #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       E,
  input  logic       ack,
  output logic [1:0] A,
  output logic       V,
  output logic       MULTI,
  output logic [7:0] CNT
);

  localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_VALID    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_d_meta;
  logic [3:0] r_ds;
  logic [7:0] r_count;
  logic [1:0] r_cand;
  logic       r_mflag;
  logic [1:0] r_a;
  logic       r_v;
  logic       r_multi;
  logic [7:0] r_cnt;

  logic       w_req;
  logic [1:0] w_code;
  logic       w_multi;
  logic       w_match;
  logic       w_last;

  logic       w_capture;
  logic       w_stable;
  logic       w_accept;
  logic       w_cnt_inc;
  logic       w_cnt_clr;
  logic       w_clr_v;

  // Two-flop synchronizer; nothing downstream looks at D directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_meta <= 4'd0;
      r_ds     <= 4'd0;
    end else begin
      r_d_meta <= D;
      r_ds     <= r_d_meta;
    end
  end

  always_comb begin
    w_code = 2'd0;
    if (r_ds[3])      w_code = 2'd3;
    else if (r_ds[2]) w_code = 2'd2;
    else if (r_ds[1]) w_code = 2'd1;
    else              w_code = 2'd0;
  end

  assign w_req   = |r_ds;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(r_ds & (r_ds - 4'd1));
  assign w_match = w_req && (w_code == r_cand);
  assign w_last  = (r_count == LP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (E && w_req) w_state_next = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!E || !w_match) w_state_next = ST_IDLE;
        else if (w_last)    w_state_next = ST_VALID;
      end
      ST_VALID: begin
        // Disable wins over acknowledge.
        if (!E)       w_state_next = ST_IDLE;
        else if (ack) w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!E)                  w_state_next = ST_IDLE;
        else if (!w_req && w_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output/control strobes decoded from the current state
  always_comb begin
    w_capture = (r_state == ST_IDLE) && E && w_req;
    w_stable  = (r_state == ST_DEBOUNCE) && E && w_match;
    w_accept  = w_stable && w_last;
    w_cnt_inc = (w_stable && !w_last) ||
                ((r_state == ST_RELEASE) && E && !w_req && !w_last);
    w_cnt_clr = w_capture ||
                ((r_state == ST_VALID) && E && ack) ||
                ((r_state == ST_RELEASE) && w_req);
    w_clr_v   = (r_state == ST_VALID) && (!E || ack);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
      r_cand  <= 2'd0;
      r_mflag <= 1'b0;
      r_a     <= 2'd0;
      r_v     <= 1'b0;
      r_multi <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      if (w_cnt_clr)      r_count <= 8'd0;
      else if (w_cnt_inc) r_count <= r_count + 8'd1;

      if (w_capture) begin
        r_cand  <= w_code;
        r_mflag <= w_multi;
      end

      if (w_accept) begin
        r_a     <= r_cand;
        r_multi <= r_mflag;
        r_v     <= 1'b1;
        r_cnt   <= r_cnt + 8'd1;
      end else if (w_clr_v) begin
        r_v     <= 1'b0;
      end
    end
  end

  assign A     = r_a;
  assign V     = r_v;
  assign MULTI = r_multi;
  assign CNT   = r_cnt;

endmodule
